// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Processor-wide constants shared by the control unit, the call
//             stack and the writeback mux. Provides the machine word width,
//             the call-stack depth, the writeback-select codes and the
//             encoding of the stack operation formed from {push, pop}.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int WORD_W      = 16;
   localparam int STACK_DEPTH = 16;

   // Writeback-select codes for the destination-data mux
   localparam logic [1:0] WB_ALU   = 2'b00;
   localparam logic [1:0] WB_MEM   = 2'b01;
   localparam logic [1:0] WB_STACK = 2'b10;

   // Stack operation, encoded directly as {push, pop}
   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_REPL = 2'b11
   } stack_op_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/stack_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : stack_regfile
//  Purpose  : DEPTH x WIDTH storage array for the call stack. One synchronous
//             write port and one asynchronous read port. The array is not
//             reset: its contents are only meaningful below the live count.
//  Ports    : clk      - system clock
//             i_we     - write enable
//             i_waddr  - write address
//             i_wdata  - write data
//             i_raddr  - read address
//             o_rdata  - read data (combinational from i_raddr)
//  Revision : 1.0 - initial release
// ============================================================================
module stack_regfile
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = STACK_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : stack_regfile
`default_nettype wire

// File: rtl/call_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module   : call_stack_unit
//  Purpose  : Hardware LIFO for CALL/RET return addresses and PUSH/POP
//             operands. The registered top-of-stack feeds the writeback mux
//             (select WB_STACK) one cycle after the strobe.
//  Ports    : clk          - system clock, rising edge
//             rst_n        - asynchronous active-low reset
//             i_push       - push strobe
//             i_pop        - pop strobe (push+pop replaces the top entry)
//             i_push_data  - value to push
//             i_clr_err    - clears the sticky overflow/underflow flags
//             o_stack_out  - registered top of stack, 0 when empty
//             o_count      - number of valid entries (0..DEPTH)
//             o_empty      - count == 0
//             o_full       - count == DEPTH
//             o_overflow   - sticky: push attempted while full
//             o_underflow  - sticky: pop attempted while empty
//  Revision : 1.0 - initial release
// ============================================================================
module call_stack_unit
   import cpu_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = STACK_DEPTH,
   parameter int PTR_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_clr_err,
   output logic [WIDTH-1:0] o_stack_out,
   output logic [PTR_W-1:0] o_count,
   output logic             o_empty,
   output logic             o_full,
   output logic             o_overflow,
   output logic             o_underflow
);

   localparam int AW = PTR_W - 1;

   logic [PTR_W-1:0] r_count;
   logic [WIDTH-1:0] r_stack_out;
   logic             r_overflow;
   logic             r_underflow;

   stack_op_e        w_op;
   logic             w_empty;
   logic             w_full;
   logic [PTR_W-1:0] w_next_count;
   logic [WIDTH-1:0] w_next_out;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [AW-1:0]    w_raddr;
   logic [WIDTH-1:0] w_rdata;
   logic             w_ov_set;
   logic             w_un_set;

   assign w_op    = stack_op_e'({i_push, i_pop});
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == PTR_W'(DEPTH));

   // Entry just below the current top: becomes the new top on a pop.
   // Wraps harmlessly when count < 2; that case drives 0 instead.
   assign w_raddr = r_count[AW-1:0] - AW'(2);

   stack_regfile #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_regfile (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (i_push_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_next_count = r_count;
      w_next_out   = r_stack_out;
      w_we         = 1'b0;
      w_waddr      = r_count[AW-1:0];
      w_ov_set     = 1'b0;
      w_un_set     = 1'b0;
      case (w_op)
         OP_PUSH: begin
            if (w_full) begin
               w_ov_set = 1'b1;
            end else begin
               w_we         = 1'b1;
               w_next_count = r_count + PTR_W'(1);
               w_next_out   = i_push_data;
            end
         end
         OP_POP: begin
            if (w_empty) begin
               w_un_set = 1'b1;
            end else begin
               w_next_count = r_count - PTR_W'(1);
               w_next_out   = (r_count >= PTR_W'(2)) ? w_rdata : '0;
            end
         end
         OP_REPL: begin
            // Replace the top in place; on an empty stack it degrades to a
            // plain push into entry 0 and flags the missing pop.
            w_we       = 1'b1;
            w_next_out = i_push_data;
            if (w_empty) begin
               w_un_set     = 1'b1;
               w_next_count = PTR_W'(1);
            end else begin
               w_waddr = r_count[AW-1:0] - AW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count     <= '0;
         r_stack_out <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_next_count;
         r_stack_out <= w_next_out;
         // A new error on the same edge as the clear wins
         r_overflow  <= (r_overflow  & ~i_clr_err) | w_ov_set;
         r_underflow <= (r_underflow & ~i_clr_err) | w_un_set;
      end
   end

   assign o_stack_out = r_stack_out;
   assign o_count     = r_count;
   assign o_empty     = w_empty;
   assign o_full      = w_full;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule : call_stack_unit
`default_nettype wire

// File: doc/call_stack_unit.md
Name: call_stack_unit

Overview:
- Hardware LIFO holding return addresses and saved operands for CALL/RET and PUSH/POP instructions.
- Sits directly upstream of the datapath writeback select. Its stack_out is the third source (select code 2'b10) of the destination-data mux.
- Fed by the control unit (push/pop strobes) and by the incremented PC or a register value (push_data).

Parameters:
- WIDTH, 16, data word width in bits; matches the processor word.
- DEPTH, 16, number of stack entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH)+1, width of the occupancy count (covers 0..DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  push strobe, sampled on the rising clk edge.
- pop  input  1  pop strobe, sampled on the rising clk edge.
- push_data  input  WIDTH  value to push (PC+1 for CALL, register data for PUSH).
- clr_err  input  1  clears the sticky overflow/underflow flags.
- stack_out  output  WIDTH  current top of stack; 0 when empty.
- count  output  PTR_W  number of valid entries.
- empty  output  1  high when count==0.
- full  output  1  high when count==DEPTH.
- overflow  output  1  sticky flag: a push was attempted while full.
- underflow  output  1  sticky flag: a pop was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous): count=0, stack_out=0, empty=1, full=0, overflow=0, underflow=0. Storage contents are don't-care. Reset mid-operation discards all entries at once.
- stack_out is registered:
  - It always equals the top entry and updates on the same edge that commits the push/pop.
  - Data is visible one cycle after the strobe, ready for the writeback mux in the following cycle.
  - It is driven 0 whenever empty.
- Each edge, evaluated on {push,pop}:
  - 00: hold.
  - 10, not full: write push_data at index count; count+1; stack_out=push_data.
  - 10, full: no write; count unchanged; overflow<=1.
  - 01, not empty: count-1; stack_out=entry[count-2] if count>=2, else 0.
  - 01, empty: no change; underflow<=1.
  - 11, not empty: replace top (pop then push). count unchanged; entry[count-1]=push_data; stack_out=push_data. Used for RET-and-CALL back-to-back.
  - 11, empty: performed as a push only (count=1, stack_out=push_data); underflow<=1.
- Full/empty boundaries: full is only reachable by pushes. A push when count==DEPTH never wraps and never overwrites entry 0.
- empty and full are combinational decodes of the registered count. They are never both high.
- Sticky flags:
  - clr_err clears overflow/underflow on the next edge.
  - If a new error occurs on the same edge as clr_err, the set wins.
- No combinational path from push/pop/push_data to any output.
- All arithmetic on count is unsigned, PTR_W bits. The index into storage uses the low PTR_W-1 bits.

Decomposition:
- Shared package (cpu_pkg): WORD_W=16, STACK_DEPTH=16, and the writeback-select encoding (WB_ALU=2'b00, WB_MEM=2'b01, WB_STACK=2'b10). The control unit and writeback mux use the same constants.
- One sub-module: stack_regfile.
  - DEPTH x WIDTH register array with one synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr -> rdata).
  - No reset on the array.
- call_stack_unit owns count, stack_out, flags and the push/pop decision logic.

Test Plan:
- Reset then idle 3 cycles -> count=0, empty=1, stack_out=0x0000, overflow=underflow=0.
- Push 0x0101, 0x0202, 0x0303 on consecutive cycles, then pop x3 -> count reaches 3 with stack_out=0x0303. Pops show 0x0202, 0x0101, 0x0000, ending with empty=1.
- Fill with 16 pushes (0x1000+i), then push 0xDEAD -> full=1, count=16, overflow=1, stack_out=0x100F.
  - Then pop 16 times -> values 0x100E..0x1000 then 0; underflow stays 0.
- Pop while empty -> underflow=1, count=0.
  - Assert clr_err with another empty pop on the same edge -> underflow remains 1.
  - clr_err alone -> underflow=0.
- Push 0x00AA, then push+pop with push_data 0x00BB -> count=1, stack_out=0x00BB.
  - push+pop while empty with 0x0055 -> count=1, stack_out=0x0055, underflow=1.
- Push 4 values, assert rst_n low asynchronously mid-cycle -> outputs return to reset values immediately, with no clock edge needed.
  - After release, pop -> underflow=1.
